arith_op_fsm: RTL and testbench
===============================

// Module: arith_op_fsm
// PURPOSE
//  Parametrised control FSM for the UMIX arithmetic instructions (3 add, 4 mul, 5 div, 6 nand).
//  Generalises the single-purpose instruction FSMs (cmov/addr_idx/addr_amend) in width, register count and ALU latency.
//  Sequence: reads regB and regC from reg_bank, issues them to the alu, waits, writes alu result to regA.
//  Sits beside the other instruction FSMs under control_unit; its bus drives are muxed onto reg_bank via the bus buffers.
// PARAMETERS
//  DATA_W   32            datapath width (reg data, alu operands/result)
//  NREGS    8             registers in reg_bank
//  RSEL_W   $clog2(NREGS) register select width (derived; do not override)
//  ALU_LAT  1             alu result latency in clk cycles after operands/alu_s present; legal range 1..15
// PORTS
//  clk          in   1        clock, all state on rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  start        in   1        begin instruction; sampled only in IDLE
//  opcode       in   4        instruction opcode from instr_decoder
//  reg_a        in   RSEL_W   destination register
//  reg_b        in   RSEL_W   operand 1 register
//  reg_c        in   RSEL_W   operand 2 register
//  reg_rd_data  in   DATA_W   reg_bank read data (valid 1 cycle after reg_sel)
//  reg_sel      out  RSEL_W   reg_bank select
//  reg_wdata    out  DATA_W   reg_bank write data
//  reg_we       out  1        reg_bank write strobe (bus mode: 1 = write, 0 = read)
//  alu_x        out  DATA_W   alu operand x (= regB)
//  alu_y        out  DATA_W   alu operand y (= regC)
//  alu_s        out  2        alu op: 00 add, 01 mul, 10 div (unsigned), 11 nand
//  alu_out      in   DATA_W   alu result
//  busy         out  1        high from cycle after start accepted until done cycle inclusive
//  done         out  1        1-cycle pulse: instruction retired
//  err          out  1        1-cycle pulse with done: instruction faulted, no write performed
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; reg_sel, reg_wdata, alu_x, alu_y = 0; reg_we, alu_s, busy, done, err = 0.
//  - Reset mid-operation: immediate abort to IDLE, no write issued; next start after release runs normally.
//  - States: IDLE -> RD_B -> RD_C -> EXEC -> WAIT -> WB -> IDLE.
//  - IDLE: start=1 at edge -> RD_B; opcodes 3/4/5/6 map to alu_s 00/01/10/11, latched with reg_a/b/c.
//  - Other opcode in IDLE with start: go straight to WB with err=1, done=1, reg_we=0 (1-cycle fault).
//  - RD_B: reg_sel=b, reg_we=0. RD_C: capture reg_rd_data as B, reg_sel=c.
//  - EXEC: capture C; drive alu_x=B, alu_y=C, alu_s; load wait counter with ALU_LAT-1; operands held stable until WB exits.
//  - WAIT: counts down; exits to WB when counter = 0 (ALU_LAT=1 -> one WAIT cycle).
//  - WB: reg_sel=a, reg_wdata=alu_out, reg_we=1, done=1 for exactly one cycle, then IDLE.
//  - Latency: start edge to done cycle = 4 + ALU_LAT cycles; back-to-back start allowed in cycle after WB.
//  - start while busy: ignored, no queuing. opcode/reg_* changes while busy: ignored (latched).
//  - Width: result truncated to DATA_W (add/mul wrap modulo 2^DATA_W); block does no arithmetic itself.
//  - a==b, a==c, b==c legal: operands read before write.
// CONFIGURATION
//  ARITH_DIVZERO_TRAP_EN defined: in EXEC, op=div and C==0 -> skip WAIT, go to WB with reg_we=0, err=1, done=1;
//    latency 4 cycles; regA unchanged.
//  Not defined: div by zero runs like any op; regA receives alu_out (alu-defined value); err never set for div.
// TESTING
//  1 Reg1=0x2c2c, reg2=0x8f8f, op3 a=0 b=1 c=2 -> reg0=0xbbbb, done at start+5 (ALU_LAT=1), err=0.
//  2 op4 regB=0x10000, regC=0x10000 (DATA_W=32) -> regA=0x0 (wrap); op6 0xffff0000 nand 0xff00ff00 -> 0x00ffffff.
//  3 op5 regC=0: with ARITH_DIVZERO_TRAP_EN -> err=1, done at start+4, regA unchanged; without -> err=0, write occurs.
//  4 start with opcode 7 -> done=err=1 next cycle, reg_we never asserted, busy back to 0.
//  5 start pulsed again during WAIT, and reset_n=0 during EXEC -> 2nd start ignored; reset clears all outputs, no write.
//  6 Rerun 1 with DATA_W=16, NREGS=4, ALU_LAT=3 -> reg0=0xbbbb, done at start+7.

Source files
------------

// File: rtl/arith_op_fsm.sv
// arith_op_fsm: control FSM for the UMIX arithmetic instructions
// (3 add, 4 mul, 5 div, 6 nand). It reads regB and regC from reg_bank,
// issues them to the alu, waits ALU_LAT cycles and writes the result to regA.
// Optional feature: define ARITH_DIVZERO_TRAP_EN to fault a divide by zero
// in EXEC (no write, err pulse) instead of writing the alu-defined value.
module arith_op_fsm #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned RSEL_W  = $clog2(NREGS),
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [RSEL_W-1:0] reg_a,
  input  logic [RSEL_W-1:0] reg_b,
  input  logic [RSEL_W-1:0] reg_c,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [RSEL_W-1:0] reg_sel,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [1:0]        alu_s,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_B = 3'd1,
    RD_C = 3'd2,
    EXEC = 3'd3,
    WAIT = 3'd4,
    WB   = 3'd5
  } state_t;

  state_t             state;
  logic [RSEL_W-1:0]  a_q;
  logic [RSEL_W-1:0]  c_q;
  logic [1:0]         op_q;
  logic [DATA_W-1:0]  b_q;
  logic [CNT_W-1:0]   cnt;

  // Instruction sequencer; every output is set on entry to the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_q       <= '0;
      c_q       <= '0;
      op_q      <= '0;
      b_q       <= '0;
      cnt       <= '0;
      reg_sel   <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_s     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            a_q  <= reg_a;
            c_q  <= reg_c;
            case (opcode)
              4'd3: begin op_q <= 2'b00; reg_sel <= reg_b; state <= RD_B; end
              4'd4: begin op_q <= 2'b01; reg_sel <= reg_b; state <= RD_B; end
              4'd5: begin op_q <= 2'b10; reg_sel <= reg_b; state <= RD_B; end
              4'd6: begin op_q <= 2'b11; reg_sel <= reg_b; state <= RD_B; end
              default: begin
                // Unsupported opcode: one-cycle fault, no register write.
                done  <= 1'b1;
                err   <= 1'b1;
                state <= WB;
              end
            endcase
          end
        end
        RD_B: begin
          reg_sel <= c_q;
          state   <= RD_C;
        end
        RD_C: begin
          b_q   <= reg_rd_data;
          state <= EXEC;
        end
        EXEC: begin
          alu_x   <= b_q;
          alu_y   <= reg_rd_data;
          alu_s   <= op_q;
          reg_sel <= a_q;
          cnt     <= CNT_W'(ALU_LAT - 1);
          state   <= WAIT;
`ifdef ARITH_DIVZERO_TRAP_EN
          if (op_q == 2'b10 && reg_rd_data == '0) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= WB;
          end
`endif
        end
        WAIT: begin
          if (cnt == '0) begin
            reg_wdata <= alu_out;
            reg_we    <= 1'b1;
            done      <= 1'b1;
            state     <= WB;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WB: begin
          reg_we <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_op_fsm.sv
// Self-checking bench for arith_op_fsm: register bank and alu models around
// the FSM, a table of instruction vectors, plus start-while-busy and
// reset-mid-operation sequences.
module tb_arith_op_fsm;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NREGS   = 8;
  localparam int unsigned RSEL_W  = 3;
  localparam int unsigned ALU_LAT = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        opcode = '0;
  logic [RSEL_W-1:0] reg_a = '0, reg_b = '0, reg_c = '0;
  logic [DATA_W-1:0] reg_rd_data = '0;
  logic [RSEL_W-1:0] reg_sel;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic [DATA_W-1:0] alu_x, alu_y, alu_out;
  logic [1:0]        alu_s;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  logic [DATA_W-1:0] regs [NREGS];
  logic              bd_we = 1'b0;
  logic [RSEL_W-1:0] bd_idx = '0;
  logic [DATA_W-1:0] bd_val = '0;

  arith_op_fsm #(.DATA_W(DATA_W), .NREGS(NREGS), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_rd_data(reg_rd_data),
    .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_out(alu_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register bank model: registered read, write strobe, bench preload port.
  always @(posedge clk) begin
    if (bd_we) regs[bd_idx] <= bd_val;
    else if (reg_we) regs[reg_sel] <= reg_wdata;
    reg_rd_data <= regs[reg_sel];
  end

  // Event counters for done pulses and write strobes.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (reg_we) we_cnt <= we_cnt + 1;
  end

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y,
                                              input logic [1:0] s);
    case (s)
      2'b00:   return x + y;
      2'b01:   return x * y;
      2'b10:   return (y == '0) ? '1 : x / y;
      default: return ~(x & y);
    endcase
  endfunction

  assign alu_out = alu_f(alu_x, alu_y, alu_s);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [RSEL_W-1:0] idx, input logic [DATA_W-1:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one instruction; returns cycles from start edge to done and err seen.
  task automatic run(input logic [3:0] op, input logic [RSEL_W-1:0] a,
                     input logic [RSEL_W-1:0] b, input logic [RSEL_W-1:0] c,
                     output int lat, output logic e);
    @(negedge clk);
    opcode = op; reg_a = a; reg_b = b; reg_c = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode = 4'hf; reg_a = 3'd7; reg_b = 3'd7; reg_c = 3'd7;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = err;
  endtask

  typedef struct {
    logic [3:0]        op;
    logic [RSEL_W-1:0] a, b, c;
    logic [DATA_W-1:0] vb, vc, exp;
    logic              exp_err;
    int                exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    logic e;
    int d0, w0;
    string nm;

    vecs[0] = '{4'd3, 3'd0, 3'd1, 3'd2, 32'h0000_2c2c, 32'h0000_8f8f, 32'h0000_bbbb, 1'b0, 5};
    vecs[1] = '{4'd4, 3'd3, 3'd1, 3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 5};
    vecs[2] = '{4'd6, 3'd4, 3'd5, 3'd6, 32'hffff_0000, 32'hff00_ff00, 32'h00ff_ffff, 1'b0, 5};
    vecs[3] = '{4'd5, 3'd7, 3'd1, 3'd2, 32'd100,       32'd7,        32'd14,        1'b0, 5};
    vecs[4] = '{4'd3, 3'd1, 3'd1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 5};
`ifdef ARITH_DIVZERO_TRAP_EN
    vecs[5] = '{4'd5, 3'd2, 3'd3, 3'd4, 32'd50,        32'd0,        32'hdead_beef, 1'b1, 4};
`else
    vecs[5] = '{4'd5, 3'd2, 3'd3, 3'd4, 32'd50,        32'd0,        32'hffff_ffff, 1'b0, 5};
`endif
    vecs[6] = '{4'd7, 3'd0, 3'd1, 3'd2, 32'd1,         32'd2,        32'hdead_beef, 1'b1, 1};
    vecs[7] = '{4'd0, 3'd5, 3'd6, 3'd7, 32'd1,         32'd2,        32'hdead_beef, 1'b1, 1};
    vecs[8] = '{4'd6, 3'd2, 3'd2, 3'd3, 32'hffff_ffff, 32'h0f0f_0f0f, 32'hf0f0_f0f0, 1'b0, 5};

    // Reset state
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    check("rst_we",    64'(reg_we), 64'd0);
    check("rst_alu_s", 64'(alu_s), 64'd0);
    check("rst_alu_x", 64'(alu_x), 64'd0);
    check("rst_sel",   64'(reg_sel), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table-driven instructions
    for (int i = 0; i < 9; i++) begin
      poke(vecs[i].a, 32'hdead_beef);
      poke(vecs[i].b, vecs[i].vb);
      poke(vecs[i].c, vecs[i].vc);
      d0 = done_cnt; w0 = we_cnt;
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, lat, e);
      @(negedge clk);
      nm = $sformatf("v%0d", i);
      check({nm, "_lat"}, 64'(lat), 64'(vecs[i].exp_lat));
      check({nm, "_err"}, 64'(e), 64'(vecs[i].exp_err));
      check({nm, "_rega"}, 64'(regs[vecs[i].a]), 64'(vecs[i].exp));
      check({nm, "_we"}, 64'(we_cnt - w0), vecs[i].exp_err ? 64'd0 : 64'd1);
      check({nm, "_done1"}, 64'(done_cnt - d0), 64'd1);
      check({nm, "_busy"}, 64'(busy), 64'd0);
    end

    // Start pulsed again during WAIT must be ignored
    poke(3'd0, 32'd0);
    poke(3'd1, 32'd5);
    poke(3'd2, 32'd6);
    d0 = done_cnt; w0 = we_cnt;
    @(negedge clk);
    opcode = 4'd3; reg_a = 3'd0; reg_b = 3'd1; reg_c = 3'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_state_busy", 64'(busy), 64'd1);
    start = 1'b1; reg_a = 3'd3;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    check("busy_start_dones", 64'(done_cnt - d0), 64'd1);
    check("busy_start_writes", 64'(we_cnt - w0), 64'd1);
    check("busy_start_result", 64'(regs[0]), 64'd11);

    // Reset asserted during EXEC aborts without a write
    poke(3'd4, 32'h1111_1111);
    poke(3'd5, 32'd3);
    poke(3'd6, 32'd4);
    d0 = done_cnt; w0 = we_cnt;
    @(negedge clk);
    opcode = 4'd3; reg_a = 3'd4; reg_b = 3'd5; reg_c = 3'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_alu_x", 64'(alu_x), 64'd0);
    check("midrst_alu_s", 64'(alu_s), 64'd0);
    check("midrst_sel", 64'(reg_sel), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    check("midrst_no_write", 64'(we_cnt - w0), 64'd0);
    check("midrst_rega", 64'(regs[4]), 64'h1111_1111);

    // Normal operation after reset release
    run(4'd3, 3'd4, 3'd5, 3'd6, lat, e);
    @(negedge clk);
    check("post_rst_lat", 64'(lat), 64'd5);
    check("post_rst_rega", 64'(regs[4]), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
